// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer
// Streaming reorder stage ahead of a radix-2 FFT. Samples arrive in natural
// order and each complete frame is re-emitted in bit-reversed index order,
// or in natural order when the frame was tagged as bypass. Two frame banks
// ping-pong so one bank can fill while the other drains.
module fft_bitrev_buffer #(
   parameter int SAMPLES = 4,
   parameter int WIDTH   = 3,
   localparam int AW     = $clog2(SAMPLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_index,
   output logic             out_last
);

   localparam logic [AW-1:0] LAST_IDX = AW'(SAMPLES - 1);

   // Frame storage: two banks, no reset (contents are only read once the
   // bank's full flag says a whole frame has been written).
   logic [WIDTH-1:0] mem_q [2][SAMPLES];

   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
   logic [1:0]    full_q,    full_d;
   logic [1:0]    bank_mode_q, bank_mode_d;

   logic          wr_fire;
   logic          rd_fire;
   logic [AW-1:0] rd_cnt_rev;
   logic [AW-1:0] src_idx;

   // Bit-reversed read counter: bit gi of the result is bit AW-1-gi of the count.
   generate
      for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
         assign rd_cnt_rev[gi] = rd_cnt_q[AW-1-gi];
      end
   endgenerate

   // Handshake outputs and read-side addressing, all straight from registers.
   always_comb begin
      in_ready  = !full_q[wr_bank_q];
      out_valid = full_q[rd_bank_q];
      src_idx   = bank_mode_q[rd_bank_q] ? rd_cnt_q : rd_cnt_rev;
      out_data  = mem_q[rd_bank_q][src_idx];
      out_index = src_idx;
      out_last  = out_valid && (rd_cnt_q == LAST_IDX);
      wr_fire   = in_valid && in_ready;
      rd_fire   = out_valid && out_ready;
   end

   // Next-state for counters, bank pointers, full flags and per-bank mode.
   // A write only ever targets a non-full bank and a read only a full one,
   // so a completing write and a completing read never touch the same bit.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      full_d      = full_q;
      bank_mode_d = bank_mode_q;

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (wr_cnt_q == '0) begin
            bank_mode_d[wr_bank_q] = bypass;
         end
         if (wr_cnt_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end

      if (rd_fire) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_cnt_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
         end
      end
   end

   // Control state register; reset discards any partial or pending frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         full_q      <= '0;
         bank_mode_q <= '0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         full_q      <= full_d;
         bank_mode_q <= bank_mode_d;
      end
   end

   // Sample capture into the current write bank.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_bank_q][wr_cnt_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb_fft_bitrev_buffer
// Directed vectors with hand-computed expectations for the bit-reverse
// frame buffer (SAMPLES=4/WIDTH=3 instance plus a SAMPLES=8/WIDTH=4 one).
module tb_fft_bitrev_buffer;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // SAMPLES=4, WIDTH=3 instance
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_data = '0;
   logic       bypass = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_data;
   logic [1:0] out_index;
   logic       out_last;

   // SAMPLES=8, WIDTH=4 instance
   logic       in_valid8 = 1'b0;
   logic       in_ready8;
   logic [3:0] in_data8 = '0;
   logic       bypass8 = 1'b0;
   logic       out_valid8;
   logic       out_ready8 = 1'b0;
   logic [3:0] out_data8;
   logic [2:0] out_index8;
   logic       out_last8;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   fft_bitrev_buffer #(.SAMPLES(4), .WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bypass(bypass),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last)
   );

   fft_bitrev_buffer #(.SAMPLES(8), .WIDTH(4)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .bypass(bypass8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .out_index(out_index8), .out_last(out_last8)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int d, input bit byp);
      in_valid = 1'b1;
      in_data  = 3'(d);
      bypass   = byp;
      check_eq({tag, ".in_ready"}, int'(in_ready), 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop(input string tag, input int d, input int idx, input int last);
      out_ready = 1'b1;
      check_eq({tag, ".out_valid"}, int'(out_valid), 1);
      check_eq({tag, ".out_data"},  int'(out_data),  d);
      check_eq({tag, ".out_index"}, int'(out_index), idx);
      check_eq({tag, ".out_last"},  int'(out_last),  last);
      step();
   endtask

   int frm_in  [3][4] = '{'{5, 1, 6, 3}, '{2, 7, 4, 0}, '{3, 3, 1, 6}};
   int frm_out [3][4] = '{'{5, 6, 1, 3}, '{2, 4, 7, 0}, '{3, 1, 3, 6}};
   int rev4    [4]    = '{0, 2, 1, 3};
   int exp8    [8]    = '{0, 4, 2, 6, 1, 5, 3, 7};

   initial begin
      // ---------------- reset state ----------------
      step();
      step();
      reset = 1'b0;
      check_eq("rst.in_ready",  int'(in_ready),  1);
      check_eq("rst.out_valid", int'(out_valid), 0);
      check_eq("rst.out_last",  int'(out_last),  0);
      check_eq("rst.out_index", int'(out_index), 0);
      check_eq("rst.out_valid8", int'(out_valid8), 0);

      // ---------------- bit-reverse order ----------------
      out_ready = 1'b1;
      push("br.w0", 6, 1'b0);
      push("br.w1", 2, 1'b0);
      push("br.w2", 0, 1'b0);
      check_eq("br.valid_before_last", int'(out_valid), 0);
      push("br.w3", 7, 1'b0);
      pop("br.r0", 6, 0, 0);
      pop("br.r1", 0, 2, 0);
      pop("br.r2", 2, 1, 0);
      pop("br.r3", 7, 3, 1);
      check_eq("br.drained", int'(out_valid), 0);

      // ---------------- bypass order (bypass only on first sample) ----------------
      push("bp.w0", 6, 1'b1);
      push("bp.w1", 2, 1'b0);
      push("bp.w2", 0, 1'b0);
      push("bp.w3", 7, 1'b0);
      pop("bp.r0", 6, 0, 0);
      pop("bp.r1", 2, 1, 0);
      pop("bp.r2", 0, 2, 0);
      pop("bp.r3", 7, 3, 1);

      // ---------------- SAMPLES=8, WIDTH=4 ----------------
      out_ready8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid8 = 1'b1;
         in_data8  = 4'(i);
         step();
      end
      in_valid8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("s8.valid%0d", k), int'(out_valid8), 1);
         check_eq($sformatf("s8.data%0d", k),  int'(out_data8),  exp8[k]);
         check_eq($sformatf("s8.index%0d", k), int'(out_index8), exp8[k]);
         check_eq($sformatf("s8.last%0d", k),  int'(out_last8),  (k == 7) ? 1 : 0);
         step();
      end
      check_eq("s8.drained", int'(out_valid8), 0);

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      push("bk.a0", 1, 1'b0);
      push("bk.a1", 2, 1'b0);
      push("bk.a2", 3, 1'b0);
      push("bk.a3", 4, 1'b0);
      check_eq("bk.held_data0", int'(out_data), 1);
      push("bk.b0", 5, 1'b0);
      push("bk.b1", 6, 1'b0);
      push("bk.b2", 7, 1'b0);
      push("bk.b3", 0, 1'b0);
      check_eq("bk.in_ready_full", int'(in_ready), 0);
      check_eq("bk.held_data1",  int'(out_data),  1);
      check_eq("bk.held_index1", int'(out_index), 0);
      check_eq("bk.held_last1",  int'(out_last),  0);
      // ninth sample offered while stalled: must be ignored
      in_valid = 1'b1;
      in_data  = 3'd5;
      step();
      check_eq("bk.in_ready_stall", int'(in_ready), 0);
      check_eq("bk.held_data2", int'(out_data), 1);
      step();
      in_valid = 1'b0;
      pop("bk.ra0", 1, 0, 0);
      pop("bk.ra1", 3, 2, 0);
      check_eq("bk.in_ready_mid", int'(in_ready), 0);
      pop("bk.ra2", 2, 1, 0);
      pop("bk.ra3", 4, 3, 1);
      check_eq("bk.in_ready_back", int'(in_ready), 1);
      pop("bk.rb0", 5, 0, 0);
      pop("bk.rb1", 7, 2, 0);
      pop("bk.rb2", 6, 1, 0);
      pop("bk.rb3", 0, 3, 1);
      check_eq("bk.no_ninth", int'(out_valid), 0);

      // ---------------- continuous streaming, 3 frames ----------------
      out_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c < 12) begin
            in_valid = 1'b1;
            in_data  = 3'(frm_in[c / 4][c % 4]);
            bypass   = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         check_eq($sformatf("cs.in_ready%0d", c), int'(in_ready), 1);
         if (c >= 4) begin
            check_eq($sformatf("cs.valid%0d", c), int'(out_valid), 1);
            check_eq($sformatf("cs.data%0d", c), int'(out_data), frm_out[(c - 4) / 4][(c - 4) % 4]);
            check_eq($sformatf("cs.index%0d", c), int'(out_index), rev4[(c - 4) % 4]);
         end else begin
            check_eq($sformatf("cs.valid%0d", c), int'(out_valid), 0);
         end
         step();
      end
      check_eq("cs.drained", int'(out_valid), 0);

      // ---------------- reset mid-frame ----------------
      push("mr.w0", 5, 1'b1);
      push("mr.w1", 6, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("mr.out_valid", int'(out_valid), 0);
      check_eq("mr.in_ready",  int'(in_ready),  1);
      push("mr.n0", 1, 1'b0);
      push("mr.n1", 2, 1'b0);
      push("mr.n2", 3, 1'b0);
      check_eq("mr.no_stale", int'(out_valid), 0);
      push("mr.n3", 4, 1'b0);
      pop("mr.r0", 1, 0, 0);
      pop("mr.r1", 3, 2, 0);
      pop("mr.r2", 2, 1, 0);
      pop("mr.r3", 4, 3, 1);
      check_eq("mr.drained", int'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
